retro_memory_port_arbiter: RTL and testbench

//   Shares one memory-port Target (SRAM, DRAM controller) among Channels Initiators (CPU, PPU, DMA).

---
 rtl/retro_memory_port_arbiter_pkg.sv | 28 ++
 rtl/retro_memory_port_arbiter_if.sv | 17 +
 rtl/retro_memory_port_tag_fifo.sv | 48 ++++
 rtl/retro_memory_port_arbiter.sv | 96 +++++++++
 tb/tb_retro_memory_port_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/retro_memory_port_arbiter_pkg.sv
// Shared types and the rotating-priority pick used by the memory-port arbiter.
package retro_memport_pkg;

  localparam int unsigned DefaultChannels       = 2;
  localparam int unsigned DefaultMaxOutstanding = 4;
  localparam int unsigned MaxChannels           = 32;
  localparam int unsigned IdxW                  = $clog2(MaxChannels);

  typedef logic [$clog2(DefaultChannels)-1:0]     chan_id_t;
  typedef logic [$clog2(DefaultMaxOutstanding):0] occupancy_t;
  typedef logic [MaxChannels-1:0]                 req_vec_t;
  typedef logic [IdxW-1:0]                        pick_ptr_t;
  typedef logic [IdxW:0]                          pick_cnt_t;

  // One-hot grant for the first set bit of req at or after ptr, wrapping modulo n.
  function automatic req_vec_t rr_pick(input req_vec_t req, input pick_ptr_t ptr, input pick_cnt_t n);
    req_vec_t  grant;
    pick_cnt_t idx;
    grant = '0;
    for (int k = 0; k < MaxChannels; k++) begin
      idx = {1'b0, ptr} + pick_cnt_t'(k);
      if (idx >= n) idx = idx - n;
      if (pick_cnt_t'(k) < n && grant == '0 && req[idx[IdxW-1:0]]) grant[idx[IdxW-1:0]] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/retro_memory_port_arbiter_if.sv
// Memory-port bundle; Ports=Channels on the initiator side, Ports=1 on the target side.
interface retro_memport_if #(
  parameter int unsigned Ports           = 1,
  parameter int unsigned AddressBusWidth = 16,
  parameter int unsigned DataBusWidth    = 1
);
  logic [Ports*AddressBusWidth-1:0] Address;
  logic [Ports*8*DataBusWidth-1:0]  Dout;
  logic [Ports*DataBusWidth-1:0]    Access;
  logic [Ports-1:0]                 Write;
  logic [Ports-1:0]                 Ready;
  logic [Ports-1:0]                 DataReady;
  logic [8*DataBusWidth-1:0]        Din;

  modport master (output Address, Dout, Access, Write, input Ready, DataReady, Din);
  modport slave  (input Address, Dout, Access, Write, output Ready, DataReady, Din);
endinterface

// File: rtl/retro_memory_port_tag_fifo.sv
// Tag FIFO holding the issuing channel of each outstanding read; head is visible combinationally.
module retro_memory_port_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/retro_memory_port_arbiter.sv
// Shares one memory-port target among Channels initiators with in-order read-return routing.
// Build option RETRO_MEMPORT_ARB_PRIORITY_EN: channel 0 wins whenever eligible; others round-robin.
module retro_memory_port_arbiter
  import retro_memport_pkg::*;
#(
  parameter int unsigned Channels        = DefaultChannels,
  parameter int unsigned AddressBusWidth = 16,
  parameter int unsigned DataBusWidth    = 1,
  parameter int unsigned MaxOutstanding  = DefaultMaxOutstanding
) (
  input  logic            Clk,
  input  logic            Reset,
  retro_memport_if.slave  ini,
  retro_memport_if.master tgt,
  output logic            Underflow
);
  localparam int unsigned IdW = $clog2(Channels);
  localparam int unsigned DW8 = 8*DataBusWidth;

  logic [Channels-1:0] req, eligible, grant;
  logic [IdW-1:0]      ptr_q, ptr_d, gidx, head;
  logic                accept, push, pop_en, fifo_full, fifo_empty, read_block, underflow_q;

  assign pop_en     = tgt.DataReady[0] & ~fifo_empty & ~Reset;
  assign read_block = fifo_full & ~pop_en;

  for (genvar gi = 0; gi < Channels; gi++) begin : g_req
    assign req[gi]      = |ini.Access[gi*DataBusWidth +: DataBusWidth];
    assign eligible[gi] = req[gi] & ~Reset & (ini.Write[gi] | ~read_block);
  end

  always_comb begin
`ifdef RETRO_MEMPORT_ARB_PRIORITY_EN
    if (eligible[0]) grant = Channels'(1);
    else             grant = Channels'(rr_pick(req_vec_t'(eligible), pick_ptr_t'(ptr_q), pick_cnt_t'(Channels)));
`else
    grant = Channels'(rr_pick(req_vec_t'(eligible), pick_ptr_t'(ptr_q), pick_cnt_t'(Channels)));
`endif
  end

  always_comb begin
    tgt.Address = '0;
    tgt.Dout    = '0;
    tgt.Access  = '0;
    tgt.Write   = '0;
    gidx        = '0;
    for (int i = 0; i < Channels; i++) begin
      if (grant[i]) begin
        tgt.Address = ini.Address[i*AddressBusWidth +: AddressBusWidth];
        tgt.Dout    = ini.Dout[i*DW8 +: DW8];
        tgt.Access  = ini.Access[i*DataBusWidth +: DataBusWidth];
        tgt.Write   = ini.Write[i];
        gidx        = IdW'(i);
      end
    end
  end

  assign accept        = (|grant) & tgt.Ready[0];
  assign push          = accept & ~tgt.Write[0];
  assign ini.Ready     = accept ? grant : '0;
  assign ini.DataReady = pop_en ? (Channels'(1) << head) : '0;
  assign ini.Din       = tgt.Din;
  assign Underflow     = underflow_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (gidx == IdW'(Channels-1)) ? '0 : gidx + IdW'(1);
`ifdef RETRO_MEMPORT_ARB_PRIORITY_EN
    if (accept && gidx == '0) ptr_d = ptr_q;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (tgt.DataReady[0] && fifo_empty) underflow_q <= 1'b1;
    end
  end

  retro_memory_port_tag_fifo #(
    .Depth(MaxOutstanding),
    .Width(IdW)
  ) u_tag_fifo (
    .Clk  (Clk),
    .Reset(Reset),
    .push (push),
    .pop  (pop_en),
    .din  (gidx),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_retro_memory_port_arbiter.sv
// Randomized and directed bench for the memory-port arbiter against a queue-based reference model.
module tb_retro_memory_port_arbiter;
  localparam int CH = 3;
  localparam int AW = 16;
  localparam int DW = 2;
  localparam int MO = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Underflow;

  retro_memport_if #(.Ports(CH), .AddressBusWidth(AW), .DataBusWidth(DW)) ini_bus ();
  retro_memport_if #(.Ports(1),  .AddressBusWidth(AW), .DataBusWidth(DW)) tgt_bus ();

  retro_memory_port_arbiter #(
    .Channels(CH), .AddressBusWidth(AW), .DataBusWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ini(ini_bus), .tgt(tgt_bus), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_bad   = 0;

  bit              p_valid [CH];
  bit              p_write [CH];
  logic [AW-1:0]   p_addr  [CH];
  logic [8*DW-1:0] p_data  [CH];
  logic [DW-1:0]   p_mask  [CH];

  int tagq[$];
  int rr_ptr   = 0;
  bit uf_model = 0;
  logic [CH-1:0] ready_log[$];
  logic [CH-1:0] idr_log[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic arm(input int c, input bit w);
    if (!p_valid[c]) begin
      p_valid[c] = 1'b1;
      p_write[c] = w;
      p_addr[c]  = AW'($urandom);
      p_data[c]  = (8*DW)'($urandom);
      p_mask[c]  = DW'($urandom_range(1, 3));
    end
  endtask

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      ini_bus.Address[c*AW +: AW]     = p_addr[c];
      ini_bus.Dout[c*8*DW +: 8*DW]    = p_data[c];
      ini_bus.Access[c*DW +: DW]      = p_valid[c] ? p_mask[c] : '0;
      ini_bus.Write[c]                = p_write[c];
    end
    tgt_bus.Din = (8*DW)'($urandom);
  endtask

  // Expected outputs follow from the pending commands, queue occupancy and rotation pointer.
  task automatic check_model();
    int nq;
    bit pop;
    bit acc;
    int g;
    int c;
    bit elig [CH];
    logic [CH-1:0] e_ready;
    logic [CH-1:0] e_idr;
    logic [DW-1:0] e_acc;
    nq  = tagq.size();
    pop = !Reset && tgt_bus.DataReady[0] && nq > 0;
    g   = -1;
    for (int i = 0; i < CH; i++)
      elig[i] = !Reset && p_valid[i] && (p_write[i] || nq < MO || pop);
`ifdef RETRO_MEMPORT_ARB_PRIORITY_EN
    if (elig[0]) g = 0;
`endif
    for (int k = 0; k < CH; k++) begin
      c = (rr_ptr + k) % CH;
      if (g < 0 && elig[c]) g = c;
    end
    acc     = (g >= 0) && tgt_bus.Ready[0];
    e_ready = acc ? (CH'(1) << g) : '0;
    e_idr   = pop ? (CH'(1) << tagq[0]) : '0;
    e_acc   = (g >= 0) ? p_mask[g] : '0;

    check_eq("ireadys", ini_bus.Ready, e_ready);
    check_eq("taccess", tgt_bus.Access, e_acc);
    if (g >= 0) begin
      check_eq("taddress", tgt_bus.Address, p_addr[g]);
      check_eq("tdout", tgt_bus.Dout, p_data[g]);
      check_eq("twrite", tgt_bus.Write, p_write[g]);
    end
    check_eq("idataready", ini_bus.DataReady, e_idr);
    if (pop) check_eq("idin", ini_bus.Din, tgt_bus.Din);
    check_eq("underflow", Underflow, uf_model);
    ready_log.push_back(ini_bus.Ready);
    idr_log.push_back(ini_bus.DataReady);

    if (Reset) begin
      tagq.delete();
      rr_ptr   = 0;
      uf_model = 0;
    end else begin
      if (tgt_bus.DataReady[0] && nq == 0) uf_model = 1;
      if (pop) void'(tagq.pop_front());
      if (acc) begin
        if (!p_write[g]) tagq.push_back(g);
`ifdef RETRO_MEMPORT_ARB_PRIORITY_EN
        if (g != 0) rr_ptr = (g + 1) % CH;
`else
        rr_ptr = (g + 1) % CH;
`endif
        p_valid[g] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge Clk);
    check_model();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      tgt_bus.DataReady = (tagq.size() != 0);
      tick();
    end
    tgt_bus.DataReady = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      p_valid[c] = 1'b0; p_write[c] = 1'b0;
      p_addr[c] = '0; p_data[c] = '0; p_mask[c] = '0;
    end
    tgt_bus.Ready     = 1'b1;
    tgt_bus.DataReady = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    tick();
    tick();
    Reset = 1'b0;

    // Two readers every cycle: accepts and returns alternate 0,1,0,1.
    ready_log.delete(); idr_log.delete();
    for (int i = 0; i < 8; i++) begin
      arm(0, 1'b0); arm(1, 1'b0);
      tgt_bus.DataReady = (tagq.size() != 0);
      tick();
    end
    check_eq("t1_grant0", ready_log[0], 3'b001);
    check_eq("t1_grant1", ready_log[1], 3'b010);
    check_eq("t1_grant2", ready_log[2], 3'b001);
    check_eq("t1_grant3", ready_log[3], 3'b010);
    check_eq("t1_ret0", idr_log[1], 3'b001);
    check_eq("t1_ret1", idr_log[2], 3'b010);
    check_eq("t1_ret2", idr_log[3], 3'b001);
    check_eq("t1_ret3", idr_log[4], 3'b010);
    drain();

    // Fill the tag FIFO, hold the fifth read, let a write through, then release on a pop.
    for (int i = 0; i < 4; i++) begin
      arm(0, 1'b0);
      tick();
      check_eq("t2_fill", ready_log[$], 3'b001);
    end
    arm(0, 1'b0); arm(1, 1'b1);
    tick();
    check_eq("t2_write_passes", ready_log[$], 3'b010);
    tick();
    check_eq("t2_read_held", ready_log[$], 3'b000);
    tgt_bus.DataReady = 1'b1;
    tick();
    check_eq("t3_push_pop_full", ready_log[$], 3'b001);
    check_eq("t3_route_head", idr_log[$], 3'b001);
    tgt_bus.DataReady = 1'b0;
    arm(0, 1'b0);
    tick();
    check_eq("t3_still_full", ready_log[$], 3'b000);

    // Withdraw the held read, pop one (three in flight), then reset mid-operation.
    p_valid[0] = 1'b0;
    tgt_bus.DataReady = 1'b1;
    tick();
    tgt_bus.DataReady = 1'b0;
    Reset = 1'b1;
    arm(0, 1'b0); arm(2, 1'b1);
    tick();
    check_eq("t5_ready_in_reset", ready_log[$], 3'b000);
    Reset = 1'b0;
    p_valid[0] = 1'b0; p_valid[2] = 1'b0;

    // Target data with nothing outstanding: no routing, sticky underflow.
    tgt_bus.DataReady = 1'b1;
    tick();
    check_eq("t4_no_route", idr_log[$], 3'b000);
    tgt_bus.DataReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t4_sticky", Underflow, 1'b1);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    check_eq("t4_cleared", Underflow, 1'b0);

`ifdef RETRO_MEMPORT_ARB_PRIORITY_EN
    for (int i = 0; i < 6; i++) begin
      arm(0, 1'b1); arm(1, 1'b1); arm(2, 1'b1);
      tick();
      check_eq("t6_ch0_first", ready_log[$], 3'b001);
    end
    for (int i = 0; i < 6; i++) begin
      arm(1, 1'b1); arm(2, 1'b1);
      tick();
    end
    drain();
`endif

    // Random traffic with an occasional reset.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++)
        if (!p_valid[c] && ($urandom % 3 == 0)) arm(c, 1'($urandom % 2));
      tgt_bus.Ready     = ($urandom % 4 != 0);
      tgt_bus.DataReady = (tagq.size() != 0) && ($urandom % 2 == 0);
      Reset             = ($urandom % 500 == 0);
      tick();
    end
    Reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
